// File: rtl/operand_loader_if.sv
// Switch/key inputs and captured-operand outputs between the user panel and the adder.
interface operand_loader_if;
   logic [3:0] SW_DATA;
   logic       SW_CIN;
   logic       KEY_LOAD;
   logic [3:0] A;
   logic [3:0] B;
   logic       TE;
   logic       VALID;
   logic [1:0] STATE;

   modport master (
      output SW_DATA, SW_CIN, KEY_LOAD,
      input  A, B, TE, VALID, STATE
   );

   modport slave (
      input  SW_DATA, SW_CIN, KEY_LOAD,
      output A, B, TE, VALID, STATE
   );
endinterface

// File: rtl/operand_loader.sv
// Debounced pushbutton captures operand A, then B with carry-in, from one switch group.
// A clean press reaches the registered outputs DEBOUNCE_CYCLES+3 edges after the key is first sampled low.
module operand_loader #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic               CLOCK_50,
   input logic               RESET,
   operand_loader_if.slave   io
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      READY  = 2'b10
   } state_t;

   state_t        state, state_nxt;
   logic          key_s1, key_s2;
   logic          key_deb, key_deb_d;
   logic [CW-1:0] deb_cnt;
   logic          press;
   logic [3:0]    a_q, a_nxt;
   logic [3:0]    b_q, b_nxt;
   logic          te_q, te_nxt;
   logic          valid_q, valid_nxt;

   // Key idles high (released); the counter only runs while the synchronized level disagrees.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         key_s1    <= 1'b1;
         key_s2    <= 1'b1;
         key_deb   <= 1'b1;
         key_deb_d <= 1'b1;
         deb_cnt   <= '0;
      end else begin
         key_s1    <= io.KEY_LOAD;
         key_s2    <= key_s1;
         key_deb_d <= key_deb;
         if (key_s2 == key_deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            key_deb <= key_s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + CW'(1);
         end
      end
   end

   assign press = key_deb_d & ~key_deb;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state   <= LOAD_A;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         te_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= a_nxt;
         b_q     <= b_nxt;
         te_q    <= te_nxt;
         valid_q <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = a_q;
      b_nxt     = b_q;
      te_nxt    = te_q;
      valid_nxt = valid_q;
      case (state)
         LOAD_A: begin
            if (press) begin
               a_nxt     = io.SW_DATA;
               state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            if (press) begin
               b_nxt     = io.SW_DATA;
               te_nxt    = io.SW_CIN;
               valid_nxt = 1'b1;
               state_nxt = READY;
            end
         end
         READY: begin
            // Old B/TE stay visible until the next B capture overwrites them.
            if (press) begin
               a_nxt     = io.SW_DATA;
               valid_nxt = 1'b0;
               state_nxt = LOAD_B;
            end
         end
         default: begin
            state_nxt = LOAD_A;
            valid_nxt = 1'b0;
         end
      endcase
   end

   assign io.A     = a_q;
   assign io.B     = b_q;
   assign io.TE    = te_q;
   assign io.VALID = valid_q;
   assign io.STATE = state;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed test-plan scenarios plus random key/switch activity against a reference model.
module tb_operand_loader;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   operand_loader_if bus ();

   operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .io       (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit         keys[$];
   bit         seen[$];
   bit         m_deb;
   bit         m_pend;
   int         m_st;
   logic [3:0] m_a, m_b;
   logic       m_te, m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // The debounced level flips once the last N synchronized samples all disagree with it.
   task automatic model_edge();
      bit s2;
      bit flip;
      int n;
      if (rst) begin
         keys.delete();
         seen.delete();
         m_deb = 1'b1; m_pend = 1'b0; m_st = 0;
         m_a = 4'd0; m_b = 4'd0; m_te = 1'b0; m_valid = 1'b0;
         return;
      end
      if (m_pend) begin
         case (m_st)
            0: begin m_a = bus.SW_DATA; m_st = 1; end
            1: begin m_b = bus.SW_DATA; m_te = bus.SW_CIN; m_valid = 1'b1; m_st = 2; end
            default: begin m_a = bus.SW_DATA; m_valid = 1'b0; m_st = 1; end
         endcase
      end
      m_pend = 1'b0;
      s2 = (keys.size() >= 2) ? keys[keys.size()-2] : 1'b1;
      keys.push_back(bus.KEY_LOAD);
      seen.push_back(s2);
      n = seen.size();
      flip = (n >= N);
      for (int i = 0; i < N && flip; i++)
         if (seen[n-1-i] == m_deb) flip = 1'b0;
      if (flip) begin
         if (m_deb) m_pend = 1'b1;
         m_deb = ~m_deb;
      end
      if (keys.size() > 16) void'(keys.pop_front());
      if (seen.size() > 16) void'(seen.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("A",     32'(bus.A),     32'(m_a));
      check("B",     32'(bus.B),     32'(m_b));
      check("TE",    32'(bus.TE),    32'(m_te));
      check("VALID", 32'(bus.VALID), 32'(m_valid));
      check("STATE", 32'(bus.STATE), 32'(m_st));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Hold the key low for 'hold' edges then release; report edge of first STATE change and total changes.
   task automatic press(input int hold, input bit rnd_sw, output int lat, output int changes);
      logic [1:0] prev;
      prev = bus.STATE;
      lat = -1;
      changes = 0;
      bus.KEY_LOAD = 1'b0;
      for (int i = 1; i <= hold + 12; i++) begin
         if (i == hold + 1) bus.KEY_LOAD = 1'b1;
         step();
         if (bus.STATE !== prev) begin
            if (lat < 0) lat = i;
            changes++;
            prev = bus.STATE;
         end
         if (rnd_sw && i <= hold) bus.SW_DATA = 4'($urandom);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      steps(n);
      rst = 1'b0;
   endtask

   initial begin
      int lat, chg;
      rst = 1'b1;
      bus.KEY_LOAD = 1'b0;
      bus.SW_DATA  = 4'hF;
      bus.SW_CIN   = 1'b0;

      // Reset with key held low and switches at F
      steps(2);
      check("rst_state", 32'(bus.STATE), 32'd0);
      check("rst_a",     32'(bus.A),     32'd0);
      rst = 1'b0;
      press(10, 1'b0, lat, chg);
      check("rst_press_lat", 32'(lat), 32'd7);
      check("rst_press_a",   32'(bus.A), 32'hF);

      // Full entry 9 + 7 + 1
      do_reset(1);
      bus.SW_DATA = 4'd9;
      press(10, 1'b0, lat, chg);
      check("entry_a_lat", 32'(lat), 32'd7);
      check("entry_a",     32'(bus.A), 32'd9);
      check("entry_a_st",  32'(bus.STATE), 32'd1);
      bus.SW_DATA = 4'd7;
      bus.SW_CIN  = 1'b1;
      press(10, 1'b0, lat, chg);
      check("entry_b_lat", 32'(lat), 32'd7);
      check("entry_b",     32'(bus.B), 32'd7);
      check("entry_te",    32'(bus.TE), 32'd1);
      check("entry_valid", 32'(bus.VALID), 32'd1);
      check("entry_st",    32'(bus.STATE), 32'd2);
      check("entry_sum",   32'(bus.A) + 32'(bus.B) + 32'(bus.TE), 32'd17);

      // Re-entry from READY
      bus.SW_DATA = 4'd3;
      press(10, 1'b0, lat, chg);
      check("reent_a",     32'(bus.A), 32'd3);
      check("reent_valid", 32'(bus.VALID), 32'd0);
      check("reent_st",    32'(bus.STATE), 32'd1);
      check("reent_b_kept",  32'(bus.B), 32'd7);
      check("reent_te_kept", 32'(bus.TE), 32'd1);
      bus.SW_DATA = 4'd2;
      bus.SW_CIN  = 1'b0;
      press(10, 1'b0, lat, chg);
      check("reent_b",  32'(bus.B), 32'd2);
      check("reent_te", 32'(bus.TE), 32'd0);
      check("reent_v",  32'(bus.VALID), 32'd1);

      // Bounce rejection in LOAD_A
      do_reset(1);
      bus.SW_DATA = 4'd5;
      bus.KEY_LOAD = 1'b0; steps(3);
      bus.KEY_LOAD = 1'b1; steps(2);
      bus.KEY_LOAD = 1'b0; steps(2);
      bus.KEY_LOAD = 1'b1; steps(10);
      check("bounce_st", 32'(bus.STATE), 32'd0);
      check("bounce_a",  32'(bus.A), 32'd0);
      press(10, 1'b0, lat, chg);
      check("bounce_after_lat", 32'(lat), 32'd7);

      // Held key with switches changing every cycle
      do_reset(1);
      press(100, 1'b1, lat, chg);
      check("held_changes", 32'(chg), 32'd1);
      check("held_st",      32'(bus.STATE), 32'd1);

      // Reset in LOAD_B with the debounce counter at 2 and the key held low
      bus.SW_DATA = 4'hC;
      bus.SW_CIN  = 1'b1;
      bus.KEY_LOAD = 1'b0;
      steps(4);
      rst = 1'b1;
      step();
      check("midrst_st", 32'(bus.STATE), 32'd0);
      check("midrst_a",  32'(bus.A), 32'd0);
      rst = 1'b0;
      press(20, 1'b0, lat, chg);
      check("midrst_lat", 32'(lat), 32'd7);
      check("midrst_cap_a", 32'(bus.A), 32'hC);
      check("midrst_b",     32'(bus.B), 32'd0);
      check("midrst_st2",   32'(bus.STATE), 32'd1);

      // Random key runs, switch changes and occasional resets
      for (int r = 0; r < 150; r++) begin
         bus.KEY_LOAD = 1'($urandom);
         bus.SW_DATA  = 4'($urandom);
         bus.SW_CIN   = 1'($urandom);
         rst = ($urandom_range(0, 49) == 0);
         steps($urandom_range(1, 9));
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
